// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// mem_arbiter_pkg : shared FSM encoding and access-direction constants  (rev 1.0)
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : two-way round-robin pick, one-hot winner from valid bits  (rev 1.0)
// ============================================================================
`default_nettype none

module rr_pick (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] winner
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    winner = valid;
    if (valid == 2'b11) begin
      winner = last ? 2'b01 : 2'b10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : two-requester round-robin memory arbiter with timeout  (rev 1.0)
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic          req0_rw,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic [DW-1:0] req0_rdata,
  input  logic          req1_valid,
  input  logic          req1_rw,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic [DW-1:0] req1_rdata,
  output logic          mem_valid,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    grant,
  output logic          timeout_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t        state, state_next;
  logic [7:0]    cnt, cnt_next;
  logic          last, last_next;
  logic [1:0]    win;
  logic [1:0]    grant_next;
  logic          mem_valid_next, mem_rw_next;
  logic [AW-1:0] mem_addr_next;
  logic [DW-1:0] mem_wdata_next;
  logic          req0_ready_next, req1_ready_next;
  logic [DW-1:0] req0_rdata_next, req1_rdata_next;
  logic          timeout_next;
  logic [DW-1:0] done_rdata;

  rr_pick u_rr_pick (
    .valid  ({req1_valid, req0_valid}),
    .last   (last),
    .winner (win)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= 1'b1;
      grant       <= '0;
      mem_valid   <= 1'b0;
      mem_rw      <= RW_READ;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      req0_rdata  <= '0;
      req1_rdata  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      last        <= last_next;
      grant       <= grant_next;
      mem_valid   <= mem_valid_next;
      mem_rw      <= mem_rw_next;
      mem_addr    <= mem_addr_next;
      mem_wdata   <= mem_wdata_next;
      req0_ready  <= req0_ready_next;
      req1_ready  <= req1_ready_next;
      req0_rdata  <= req0_rdata_next;
      req1_rdata  <= req1_rdata_next;
      timeout_err <= timeout_next;
    end
  end

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    last_next       = last;
    grant_next      = grant;
    mem_valid_next  = mem_valid;
    mem_rw_next     = mem_rw;
    mem_addr_next   = mem_addr;
    mem_wdata_next  = mem_wdata;
    req0_ready_next = 1'b0;
    req1_ready_next = 1'b0;
    req0_rdata_next = req0_rdata;
    req1_rdata_next = req1_rdata;
    timeout_next    = 1'b0;
    // A timeout (no mem_ready) and any write complete with zero read data.
    done_rdata      = (mem_ready && mem_rw != RW_WRITE) ? mem_rdata : '0;

    case (state)
      IDLE: begin
        if (win != 2'b00) begin
          state_next     = BUSY;
          grant_next     = win;
          mem_valid_next = 1'b1;
          cnt_next       = '0;
          if (win[0]) begin
            mem_rw_next    = req0_rw;
            mem_addr_next  = req0_addr;
            mem_wdata_next = req0_wdata;
          end else begin
            mem_rw_next    = req1_rw;
            mem_addr_next  = req1_addr;
            mem_wdata_next = req1_wdata;
          end
        end
      end
      BUSY: begin
        if (mem_ready || cnt == CNT_LAST) begin
          state_next     = DONE;
          mem_valid_next = 1'b0;
          timeout_next   = !mem_ready;
          last_next      = grant[1];
          if (grant[1]) begin
            req1_ready_next = 1'b1;
            req1_rdata_next = done_rdata;
          end else begin
            req0_ready_next = 1'b1;
            req0_rdata_next = done_rdata;
          end
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
        grant_next = '0;
      end
      default: begin
        state_next     = IDLE;
        grant_next     = '0;
        mem_valid_next = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire
